// File: rtl/flatten_l2_pkg.sv
// Shared constants for the layer-2 flatten stage: memory select codes, widths, FSM states.
package flatten_l2_pkg;

    localparam int MAP_W = 32;
    localparam int MAP_H = 32;
    localparam int DW    = 20;
    localparam int AW    = 12;
    localparam int NPIX  = MAP_W * MAP_H;
    localparam int IDXW  = $clog2(NPIX);

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_K0   = 3'b011;
    localparam logic [2:0] CSEL_K1   = 3'b100;
    localparam logic [2:0] CSEL_FLT  = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_DONE
    } state_t;

endpackage

// File: rtl/flatten_l2_addr_gen.sv
// Pixel index / kernel-channel counters and the read/write addresses derived from them.
// Advances one element per step; no backpressure, the FSM paces it.
module flatten_l2_addr_gen
    import flatten_l2_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          step_i,
    output logic          ch_o,
    output logic          last_o,
    output logic [AW-1:0] rd_addr_o,
    output logic [AW-1:0] wr_addr_o
);

    logic [IDXW-1:0] idx_q, idx_d;
    logic            ch_q, ch_d;

    always_comb begin
        idx_d = idx_q;
        ch_d  = ch_q;
        if (clear_i) begin
            idx_d = '0;
            ch_d  = 1'b0;
        end else if (step_i) begin
            // kernel1 follows kernel0 for the same pixel, then move to the next pixel
            ch_d = ~ch_q;
            if (ch_q) begin
                idx_d = idx_q + IDXW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
            ch_q  <= 1'b0;
        end else begin
            idx_q <= idx_d;
            ch_q  <= ch_d;
        end
    end

    assign ch_o      = ch_q;
    assign last_o    = (idx_q == IDXW'(NPIX - 1)) && ch_q;
    assign rd_addr_o = AW'(idx_q);
    assign wr_addr_o = AW'({idx_q, ch_q});

endmodule

// File: rtl/flatten_l2.sv
// Interleaves the two pooled maps into the flatten memory, one element every 3 cycles.
// All outputs registered one cycle behind the FSM state; start is ignored while busy.
module flatten_l2
    import flatten_l2_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            crd_q, crd_d;
    logic            cwr_q, cwr_d;
    logic [2:0]      csel_q, csel_d;
    logic [AW-1:0]   caddr_rd_q, caddr_rd_d;
    logic [AW-1:0]   caddr_wr_q, caddr_wr_d;
    logic [DW-1:0]   cdata_wr_q, cdata_wr_d;

    logic            ch;
    logic            last;
    logic [AW-1:0]   rd_addr;
    logic [AW-1:0]   wr_addr;

    flatten_l2_addr_gen u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q == ST_IDLE),
        .step_i    (state_q == ST_WR),
        .ch_o      (ch),
        .last_o    (last),
        .rd_addr_o (rd_addr),
        .wr_addr_o (wr_addr)
    );

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        crd_d      = 1'b0;
        cwr_d      = 1'b0;
        csel_d     = CSEL_NONE;
        caddr_rd_d = caddr_rd_q;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RD;
                    busy_d  = 1'b1;
                end
            end
            ST_RD: begin
                crd_d      = 1'b1;
                csel_d     = ch ? CSEL_K1 : CSEL_K0;
                caddr_rd_d = rd_addr;
                state_d    = ST_CAP;
            end
            ST_CAP: begin
                crd_d   = 1'b1;
                csel_d  = csel_q;
                state_d = ST_WR;
            end
            ST_WR: begin
                // read data is valid during the CAP output cycle, which ends at this edge
                cwr_d      = 1'b1;
                csel_d     = CSEL_FLT;
                caddr_wr_d = wr_addr;
                cdata_wr_d = cdata_rd;
                state_d    = last ? ST_DONE : ST_RD;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            csel_q     <= CSEL_NONE;
            caddr_rd_q <= '0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            crd_q      <= crd_d;
            cwr_q      <= cwr_d;
            csel_q     <= csel_d;
            caddr_rd_q <= caddr_rd_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign crd      = crd_q;
    assign cwr      = cwr_q;
    assign csel     = csel_q;
    assign caddr_rd = caddr_rd_q;
    assign caddr_wr = caddr_wr_q;
    assign cdata_wr = cdata_wr_q;

endmodule

// File: tb/tb_flatten_l2.sv
// Bench for flatten_l2: memory model plus scoreboard of expected flatten writes.
module tb_flatten_l2;
    import flatten_l2_pkg::*;

    localparam int DONE_EDGE = 3 * (2 * NPIX - 1) + 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, crd, cwr;
    logic [AW-1:0] caddr_rd, caddr_wr;
    logic [DW-1:0] cdata_rd = '0;
    logic [DW-1:0] cdata_wr;
    logic [2:0]    csel;

    always #5 clk = ~clk;

    flatten_l2 dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .csel     (csel)
    );

    logic [DW-1:0] k0 [NPIX];
    logic [DW-1:0] k1 [NPIX];
    logic [DW-1:0] flt [2*NPIX];
    int            flt_gen [2*NPIX];
    int            run_id = 0;

    always @(posedge clk) begin
        if (crd) cdata_rd <= (csel == CSEL_K1) ? k1[caddr_rd[IDXW-1:0]] : k0[caddr_rd[IDXW-1:0]];
        if (cwr && csel == CSEL_FLT) begin
            flt[caddr_wr[IDXW:0]]     <= cdata_wr;
            flt_gen[caddr_wr[IDXW:0]] <= run_id;
        end
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            n;
    } exp_t;
    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ae = number of the clock edge (relative to the accepted start edge E0) just passed
    int   ae = -1000000;
    int   done_cnt = 0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        ae++;
        if (crd && cwr) chk("strobe_overlap", 1, 0);
        if (crd) chk("csel_on_read", (csel == CSEL_K0 || csel == CSEL_K1), 1);
        if (cwr) begin
            chk("csel_on_write", csel, CSEL_FLT);
            if (q.size() == 0) begin
                chk("unexpected_write", caddr_wr, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("wr_addr", caddr_wr, e.a);
                chk("wr_data", cdata_wr, e.d);
                chk("wr_cycle", ae, 3 * e.n + 3);
            end
        end
        if (ae == 1) begin
            chk("e1_crd", crd, 1);
            chk("e1_csel", csel, CSEL_K0);
            chk("e1_caddr_rd", caddr_rd, 0);
        end
        if (ae == 3) begin
            chk("e3_cwr", cwr, 1);
            chk("e3_csel", csel, CSEL_FLT);
            chk("e3_caddr_wr", caddr_wr, 0);
        end
        if (ae == 4) begin
            chk("e4_csel", csel, CSEL_K1);
            chk("e4_caddr_rd", caddr_rd, 0);
        end
        if (ae == 6) chk("e6_caddr_wr", caddr_wr, 1);
        if (done) begin
            done_cnt++;
            chk("done_cycle", ae, DONE_EDGE);
            chk("busy_low_with_done", busy, 0);
            chk("busy_high_before_done", prev_busy, 1);
        end
        if (prev_busy && !busy && !reset) chk("busy_fall_with_done", done, 1);
        prev_busy = busy;
        if (start && !busy) ae = -1;
    end

    task automatic load_exp();
        for (int i = 0; i < NPIX; i++) begin
            q.push_back('{a: AW'(2 * i),     d: k0[i], n: 2 * i});
            q.push_back('{a: AW'(2 * i + 1), d: k1[i], n: 2 * i + 1});
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_write(input int addr, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3 * 2 * NPIX + 50; c++) begin
            @(posedge clk); #1;
            if (cwr && caddr_wr == AW'(addr)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic outputs_zero(input string name);
        chk(name, {busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr}, 0);
    endtask

    task automatic run_full(input int retrig_at);
        bit ok;
        int dc0;
        int bad;
        run_id++;
        dc0 = done_cnt;
        load_exp();
        pulse_start();
        if (retrig_at >= 0) begin
            wait_write(retrig_at, ok);
            chk("retrig_point_seen", ok, 1);
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        ok = 1'b0;
        for (int c = 0; c < 7000; c++) begin
            @(posedge clk); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_seen", ok, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        chk("done_pulse_count", done_cnt - dc0, 1);
        bad = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (flt_gen[2 * i] != run_id || flt[2 * i] !== k0[i]) bad++;
            if (flt_gen[2 * i + 1] != run_id || flt[2 * i + 1] !== k1[i]) bad++;
        end
        chk("flt_contents_bad", bad, 0);
        q.delete();
    endtask

    initial begin
        bit ok;
        for (int i = 0; i < NPIX; i++) begin
            k0[i] = DW'(i);
            k1[i] = 20'h80000 | DW'(i);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        outputs_zero("reset_state");
        repeat (20) begin
            @(negedge clk);
            outputs_zero("idle_quiet");
        end

        run_full(-1);
        run_full(100);
        run_full(-1);

        // abort mid-run with reset
        run_id++;
        load_exp();
        pulse_start();
        wait_write(513, ok);
        chk("abort_point_seen", ok, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        q.delete();
        outputs_zero("abort_outputs_zero");
        @(posedge clk); #1 reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        outputs_zero("abort_stays_idle");
        chk("abort_write_513_landed", flt_gen[513] == run_id, 1);
        chk("abort_no_write_514", flt_gen[514] == run_id, 0);

        for (int i = 0; i < NPIX; i++) begin
            k0[i] = DW'($urandom);
            k1[i] = DW'($urandom);
        end
        run_full(-1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
